// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage of the MIPS pipeline.
//   state_t    : MEM-stage controller states (IDLE, WAIT)
//   BAD_DATA   : writeback value for an abandoned (timed-out) access
//   REG_ADDR_W : register-file address width
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [31:0] BAD_DATA   = 32'hDEADBEEF;
  localparam int unsigned REG_ADDR_W = 5;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Captures on the falling edge of CLK, async
// active-high reset clears every field.
//   CLK, RST        : clock / reset
//   wb_*_d          : next writeback values computed by mem_stage_ctrl
//   wb_valid        : registered slot-valid
//   wb_regwrite     : registered register-file write enable
//   wb_addr         : registered destination register
//   wb_data         : registered writeback data
module mem_wb_reg
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wb_valid_d,
  input  logic                  wb_regwrite_d,
  input  logic [REG_ADDR_W-1:0] wb_addr_d,
  input  logic [DATA_W-1:0]     wb_data_d,
  output logic                  wb_valid,
  output logic                  wb_regwrite,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data
);

  logic                  wb_valid_q;
  logic                  wb_regwrite_q;
  logic [REG_ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0]     wb_data_q;

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: consumer of the EX/MEM register.
// Issues loads/stores to data memory over a req/ack handshake, stalls the
// older stages while an access is outstanding, abandons an access after
// TIMEOUT un-acked WAIT cycles, and feeds the MEM/WB register.
// All state changes on the falling edge of CLK; RST is async, active-high.
//   in_valid, ALUresult, store_data, Wreg_addr, RegWrite, MemWrite,
//   MemRead, MemtoReg, flush : EX/MEM slot contents and squash request
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata : memory port
//   stall : hold EX/MEM and older stages (combinational)
//   wb_valid/wb_regwrite/wb_addr/wb_data : MEM/WB register outputs
//   mem_err : sticky error (timeout, or MemRead & MemWrite together)
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     ALUresult,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] Wreg_addr,
  input  logic                  RegWrite,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic                  MemtoReg,
  input  logic                  flush,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall,
  output logic                  wb_valid,
  output logic                  wb_regwrite,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  mem_err
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                state_q,    state_d;
  logic                  mem_req_q,  mem_req_d;
  logic                  mem_we_q,   mem_we_d;
  logic [DATA_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [REG_ADDR_W-1:0] wreg_q,     wreg_d;
  logic                  regwrite_q, regwrite_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  is_load_q,  is_load_d;
  logic                  squashed_q, squashed_d;
  logic [15:0]           cnt_q,      cnt_d;
  logic                  mem_err_q,  mem_err_d;

  logic                  wb_valid_d;
  logic                  wb_regwrite_d;
  logic [REG_ADDR_W-1:0] wb_addr_d;
  logic [DATA_W-1:0]     wb_data_d;

  logic issue;
  logic start;
  logic stall_c;

  assign issue = in_valid & ~flush & (MemRead | MemWrite);

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wreg_d        = wreg_q;
    regwrite_d    = regwrite_q;
    memtoreg_d    = memtoreg_q;
    is_load_d     = is_load_q;
    squashed_d    = squashed_q;
    cnt_d         = cnt_q;
    mem_err_d     = mem_err_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_addr_d     = wb_addr;
    wb_data_d     = wb_data;
    stall_c       = 1'b0;
    start         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (issue) begin
          start   = 1'b1;
          stall_c = 1'b1;
        end else if (in_valid && !flush) begin
          wb_valid_d    = 1'b1;
          wb_regwrite_d = RegWrite;
          wb_addr_d     = Wreg_addr;
          wb_data_d     = ALUresult;
        end
      end
      WAIT: begin
        stall_c = ~mem_ack;
        if (flush) squashed_d = 1'b1;
        if (mem_ack) begin
          // A flush in the ack cycle squashes the completing access and
          // also blocks a new one from the EX/MEM slot.
          state_d       = IDLE;
          mem_req_d     = 1'b0;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = regwrite_q & ~squashed_q & ~flush;
          wb_addr_d     = wreg_q;
          wb_data_d     = (is_load_q && memtoreg_q) ? mem_rdata : mem_addr_q;
          // EX/MEM advances on this edge: a queued memory op issues at once.
          if (issue) start = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = IDLE;
          mem_req_d     = 1'b0;
          mem_err_d     = 1'b1;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = 1'b0;
          wb_addr_d     = wreg_q;
          wb_data_d     = DATA_W'(BAD_DATA);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d     = WAIT;
      mem_req_d   = 1'b1;
      mem_we_d    = MemWrite;
      mem_addr_d  = ALUresult;
      mem_wdata_d = store_data;
      wreg_d      = Wreg_addr;
      regwrite_d  = RegWrite;
      memtoreg_d  = MemtoReg;
      is_load_d   = MemRead & ~MemWrite;
      squashed_d  = 1'b0;
      cnt_d       = '0;
      if (MemRead && MemWrite) mem_err_d = 1'b1;
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wreg_q      <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      is_load_q   <= 1'b0;
      squashed_q  <= 1'b0;
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wreg_q      <= wreg_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      is_load_q   <= is_load_d;
      squashed_q  <= squashed_d;
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb_reg (
    .CLK           (CLK),
    .RST           (RST),
    .wb_valid_d    (wb_valid_d),
    .wb_regwrite_d (wb_regwrite_d),
    .wb_addr_d     (wb_addr_d),
    .wb_data_d     (wb_data_d),
    .wb_valid      (wb_valid),
    .wb_regwrite   (wb_regwrite),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data)
  );

  // Stall is combinational, so it is gated by reset to read 0 during RST.
  assign stall     = stall_c & ~RST;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_err   = mem_err_q;

endmodule
